// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage: FSM state encoding, opcode constants
// and opcode classification helpers reused by the pre-decoder.
package instruction_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_e;

  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;

  localparam int CNT_W = 8;

  function automatic logic is_jump_op(input logic [5:0] op);
    return (op == OP_J) || (op == OP_JAL);
  endfunction

  function automatic logic is_branch_op(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/instruction_fetch_predecode.sv
// Combinational pre-decode of a 32-bit MIPS instruction word into the
// jump/branch controls and address fields used by the program counter.
module instruction_fetch_predecode
  import instruction_fetch_pkg::*;
(
  input  logic [31:0] ir,
  output logic        jump,
  output logic        branch,
  output logic [25:0] jump_addr,
  output logic [31:0] branch_addr
);

  // opcode classification and field extraction
  always_comb begin
    jump        = is_jump_op(ir[31:26]);
    branch      = is_branch_op(ir[31:26]);
    jump_addr   = ir[25:0];
    branch_addr = {{16{ir[15]}}, ir[15:0]};
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: issues one memory read per PC, captures the word in
// the IR, pre-decodes it and pulses pc_step once downstream has consumed it.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic              fetch_en,
  input  logic              flush,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ack,
  output logic              jump,
  output logic              branch,
  output logic [25:0]       jump_addr,
  output logic [31:0]       branch_addr,
  output logic              pc_step,
  output logic              fetch_err
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  fetch_state_e      state_r, next_state_s;
  logic              drop_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              start_s, misalign_s, req_fire_s, capture_s, timeout_s, ack_fire_s;
  logic              drop_set_s;
  logic              mem_req_valid_r, instr_valid_r, pc_step_r, fetch_err_r;
  logic [ADDR_W-1:0] mem_req_addr_r;
  logic [DATA_W-1:0] instr_r;
  logic              jump_r, branch_r;
  logic [25:0]       jump_addr_r;
  logic [31:0]       branch_addr_r;
  logic              pd_jump_s, pd_branch_s;
  logic [25:0]       pd_jump_addr_s;
  logic [31:0]       pd_branch_addr_s;

  // Decode straight from the response so the decode registers load with the IR.
  instruction_fetch_predecode u_predecode (
    .ir          (mem_rsp_data[31:0]),
    .jump        (pd_jump_s),
    .branch      (pd_branch_s),
    .jump_addr   (pd_jump_addr_s),
    .branch_addr (pd_branch_addr_s)
  );

  // next-state logic and transition events; flush overrides everything
  always_comb begin
    next_state_s = state_r;
    start_s      = 1'b0;
    misalign_s   = 1'b0;
    req_fire_s   = 1'b0;
    capture_s    = 1'b0;
    timeout_s    = 1'b0;
    ack_fire_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (fetch_en && (pc_addr[1:0] != 2'b00)) begin
          misalign_s = 1'b1;
        end else if (fetch_en && !drop_r) begin
          start_s      = 1'b1;
          next_state_s = ST_REQ;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (mem_req_valid_r && mem_req_ready) begin
          req_fire_s   = 1'b1;
          next_state_s = ST_WAIT;
        end else begin
          next_state_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (mem_rsp_valid) begin
          capture_s    = 1'b1;
          next_state_s = ST_HOLD;
        end else if (cnt_r == TIMEOUT_C) begin
          timeout_s    = 1'b1;
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (instr_ack) begin
          ack_fire_s   = 1'b1;
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_HOLD;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
    if (flush) begin
      next_state_s = ST_IDLE;
      start_s      = 1'b0;
      misalign_s   = 1'b0;
      capture_s    = 1'b0;
      timeout_s    = 1'b0;
      ack_fire_s   = 1'b0;
    end else begin
      next_state_s = next_state_s;
    end
  end

  // An outstanding request abandoned by flush leaves one response to discard;
  // a response arriving in the flush cycle itself is already being dropped.
  always_comb begin
    drop_set_s = 1'b0;
    if (flush) begin
      drop_set_s = ((state_r == ST_WAIT) && !mem_rsp_valid) ||
                   ((state_r == ST_REQ) && mem_req_valid_r && mem_req_ready);
    end else begin
      drop_set_s = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= next_state_s;
  end

  // request channel, timeout counter and drop flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req_valid_r <= 1'b0;
      mem_req_addr_r  <= '0;
      cnt_r           <= '0;
      drop_r          <= 1'b0;
    end else begin
      mem_req_valid_r <= (next_state_s == ST_REQ);
      if (start_s) mem_req_addr_r <= pc_addr;
      if (req_fire_s)                 cnt_r <= '0;
      else if (state_r == ST_WAIT)    cnt_r <= cnt_r + 8'd1;
      if (drop_set_s)                 drop_r <= 1'b1;
      else if (drop_r && mem_rsp_valid) drop_r <= 1'b0;
    end
  end

  // IR, decode outputs, pc_step pulse and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_r       <= '0;
      instr_valid_r <= 1'b0;
      jump_r        <= 1'b0;
      branch_r      <= 1'b0;
      jump_addr_r   <= 26'd0;
      branch_addr_r <= 32'd0;
      pc_step_r     <= 1'b0;
      fetch_err_r   <= 1'b0;
    end else begin
      instr_valid_r <= (next_state_s == ST_HOLD);
      if (capture_s) begin
        instr_r       <= mem_rsp_data;
        jump_r        <= pd_jump_s;
        branch_r      <= pd_branch_s;
        jump_addr_r   <= pd_jump_addr_s;
        branch_addr_r <= pd_branch_addr_s;
      end else if (next_state_s != ST_HOLD) begin
        jump_r        <= 1'b0;
        branch_r      <= 1'b0;
        jump_addr_r   <= 26'd0;
        branch_addr_r <= 32'd0;
      end
      pc_step_r <= ack_fire_s;
      if (timeout_s || misalign_s) fetch_err_r <= 1'b1;
    end
  end

  assign mem_req_valid = mem_req_valid_r;
  assign mem_req_addr  = mem_req_addr_r;
  assign instr         = instr_r;
  assign instr_valid   = instr_valid_r;
  assign jump          = jump_r;
  assign branch        = branch_r;
  assign jump_addr     = jump_addr_r;
  assign branch_addr   = branch_addr_r;
  assign pc_step       = pc_step_r;
  assign fetch_err     = fetch_err_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: table of fetch/decode vectors plus
// hand-written sequences for backpressure, flush, timeout, misalign and reset.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_addr;
  logic        fetch_en, flush, mem_req_ready, mem_rsp_valid, instr_ack;
  logic [31:0] mem_rsp_data;
  logic        mem_req_valid, instr_valid, jump, branch, pc_step, fetch_err;
  logic [31:0] mem_req_addr, instr, branch_addr;
  logic [25:0] jump_addr;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic        jump;
    logic        branch;
    logic [25:0] jaddr;
    logic [31:0] baddr;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_addr       (pc_addr),
    .fetch_en      (fetch_en),
    .flush         (flush),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_ready (mem_req_ready),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .instr_ack     (instr_ack),
    .jump          (jump),
    .branch        (branch),
    .jump_addr     (jump_addr),
    .branch_addr   (branch_addr),
    .pc_step       (pc_step),
    .fetch_err     (fetch_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    fetch_en = 1'b1; pc_addr = v.pc; mem_req_ready = 1'b1;
    tick;
    check("req_valid_c1", {31'd0, mem_req_valid}, 32'd1);
    check("req_addr_c1", mem_req_addr, v.pc);
    check("instr_valid_c1", {31'd0, instr_valid}, 32'd0);
    fetch_en = 1'b0;
    tick;
    check("req_valid_c2", {31'd0, mem_req_valid}, 32'd0);
    mem_rsp_valid = 1'b1; mem_rsp_data = v.data;
    tick;
    mem_rsp_valid = 1'b0; mem_rsp_data = 32'd0; mem_req_ready = 1'b0;
    check("instr_valid_c3", {31'd0, instr_valid}, 32'd1);
    check("instr", instr, v.data);
    check("jump", {31'd0, jump}, {31'd0, v.jump});
    check("branch", {31'd0, branch}, {31'd0, v.branch});
    check("jump_addr", {6'd0, jump_addr}, {6'd0, v.jaddr});
    check("branch_addr", branch_addr, v.baddr);
    check("pc_step_pre_ack", {31'd0, pc_step}, 32'd0);
    tick;
    check("instr_valid_hold", {31'd0, instr_valid}, 32'd1);
    check("pc_step_hold", {31'd0, pc_step}, 32'd0);
    instr_ack = 1'b1;
    tick;
    instr_ack = 1'b0;
    check("pc_step_ack", {31'd0, pc_step}, 32'd1);
    check("instr_valid_after_ack", {31'd0, instr_valid}, 32'd0);
    check("jump_gated", {31'd0, jump}, 32'd0);
    check("branch_addr_gated", branch_addr, 32'd0);
    tick;
    check("pc_step_once", {31'd0, pc_step}, 32'd0);
  endtask

  initial begin
    int waited;
    vecs[0] = '{32'h0000_0040, 32'h0800_0010, 1'b1, 1'b0, 26'h000_0010, 32'h0000_0010};
    vecs[1] = '{32'h0000_0080, 32'h1000_FFFE, 1'b0, 1'b1, 26'h000_FFFE, 32'hFFFF_FFFE};
    vecs[2] = '{32'h0000_0044, 32'h0C12_3456, 1'b1, 1'b0, 26'h012_3456, 32'h0000_3456};
    vecs[3] = '{32'h0000_0048, 32'h14A5_8000, 1'b0, 1'b1, 26'h0A5_8000, 32'hFFFF_8000};
    vecs[4] = '{32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 1'b0, 26'h000_0000, 32'h0000_0000};
    vecs[5] = '{32'h0000_1000, 32'h8C41_0004, 1'b0, 1'b0, 26'h041_0004, 32'h0000_0004};
    vecs[6] = '{32'h0000_2000, 32'h07FF_FFFF, 1'b0, 1'b0, 26'h3FF_FFFF, 32'hFFFF_FFFF};

    rst_n = 1'b0; pc_addr = 32'd0; fetch_en = 1'b0; flush = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 32'd0; instr_ack = 1'b0;
    tick; tick;
    check("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
    check("rst_req_addr", mem_req_addr, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
    rst_n = 1'b1;
    tick;
    check("idle_req_valid", {31'd0, mem_req_valid}, 32'd0);
    check("idle_pc_step", {31'd0, pc_step}, 32'd0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // backpressure: request held stable for five cycles of ready low
    fetch_en = 1'b1; pc_addr = 32'h100; mem_req_ready = 1'b0;
    tick;
    fetch_en = 1'b0; pc_addr = 32'h200;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'd0, mem_req_valid}, 32'd1);
      check("bp_addr", mem_req_addr, 32'h100);
      tick;
    end
    mem_req_ready = 1'b1;
    check("bp_valid_ready", {31'd0, mem_req_valid}, 32'd1);
    tick;
    mem_req_ready = 1'b0;
    check("bp_wait_entered", {31'd0, mem_req_valid}, 32'd0);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0800_0001;
    tick;
    mem_rsp_valid = 1'b0;
    check("bp_instr_valid", {31'd0, instr_valid}, 32'd1);
    check("bp_instr", instr, 32'h0800_0001);
    instr_ack = 1'b1;
    tick;
    instr_ack = 1'b0;
    check("bp_pc_step", {31'd0, pc_step}, 32'd1);

    // flush in WAIT, late response must be dropped
    fetch_en = 1'b1; pc_addr = 32'h300; mem_req_ready = 1'b1;
    tick;
    fetch_en = 1'b0;
    tick;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    check("fl_req_valid", {31'd0, mem_req_valid}, 32'd0);
    check("fl_instr_valid", {31'd0, instr_valid}, 32'd0);
    fetch_en = 1'b1; pc_addr = 32'h400;
    tick;
    check("fl_drop_no_req1", {31'd0, mem_req_valid}, 32'd0);
    tick;
    check("fl_drop_no_req2", {31'd0, mem_req_valid}, 32'd0);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0800_0055;
    tick;
    mem_rsp_valid = 1'b0; mem_req_ready = 1'b0;
    check("fl_discard_valid", {31'd0, instr_valid}, 32'd0);
    check("fl_discard_ir", instr, 32'h0800_0001);
    check("fl_no_req3", {31'd0, mem_req_valid}, 32'd0);
    tick;
    fetch_en = 1'b0;
    check("fl_fresh_req", {31'd0, mem_req_valid}, 32'd1);
    check("fl_fresh_addr", mem_req_addr, 32'h400);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    check("fl_req_abort", {31'd0, mem_req_valid}, 32'd0);

    // flush and ack together: flush wins, no pc_step
    fetch_en = 1'b1; pc_addr = 32'h500; mem_req_ready = 1'b1;
    tick;
    fetch_en = 1'b0;
    tick;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1000_0003;
    tick;
    mem_rsp_valid = 1'b0; mem_req_ready = 1'b0;
    check("fa_instr_valid", {31'd0, instr_valid}, 32'd1);
    check("fa_branch", {31'd0, branch}, 32'd1);
    flush = 1'b1; instr_ack = 1'b1;
    tick;
    flush = 1'b0; instr_ack = 1'b0;
    check("fa_pc_step", {31'd0, pc_step}, 32'd0);
    check("fa_instr_valid_off", {31'd0, instr_valid}, 32'd0);
    check("fa_branch_gated", {31'd0, branch}, 32'd0);
    tick;
    check("fa_pc_step_later", {31'd0, pc_step}, 32'd0);

    // timeout: no response at all
    fetch_en = 1'b1; pc_addr = 32'h600; mem_req_ready = 1'b1;
    tick;
    fetch_en = 1'b0;
    tick;
    mem_req_ready = 1'b0;
    waited = 0;
    while (!fetch_err && waited < 400) begin
      tick;
      waited++;
    end
    check("to_cycles", waited, 32'd256);
    check("to_instr_valid", {31'd0, instr_valid}, 32'd0);
    check("to_req_valid", {31'd0, mem_req_valid}, 32'd0);
    run_vec(vecs[0]);
    check("to_sticky", {31'd0, fetch_err}, 32'd1);

    // reset clears the sticky error
    rst_n = 1'b0;
    tick;
    check("rst2_fetch_err", {31'd0, fetch_err}, 32'd0);
    check("rst2_instr", instr, 32'd0);
    rst_n = 1'b1;
    tick;

    // misaligned PC
    fetch_en = 1'b1; pc_addr = 32'h42;
    tick;
    fetch_en = 1'b0;
    check("mis_fetch_err", {31'd0, fetch_err}, 32'd1);
    check("mis_no_req", {31'd0, mem_req_valid}, 32'd0);
    tick;
    check("mis_no_req_later", {31'd0, mem_req_valid}, 32'd0);

    // asynchronous reset in the middle of REQ
    fetch_en = 1'b1; pc_addr = 32'h700; mem_req_ready = 1'b0;
    tick;
    fetch_en = 1'b0;
    check("ar_req_valid", {31'd0, mem_req_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_req_valid_off", {31'd0, mem_req_valid}, 32'd0);
    check("ar_req_addr", mem_req_addr, 32'd0);
    check("ar_fetch_err", {31'd0, fetch_err}, 32'd0);
    check("ar_instr", instr, 32'd0);
    tick;
    rst_n = 1'b1; mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0800_ABCD;
    tick;
    mem_rsp_valid = 1'b0;
    check("ar_late_rsp_valid", {31'd0, instr_valid}, 32'd0);
    check("ar_late_rsp_ir", instr, 32'd0);
    run_vec(vecs[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
